// File: rtl/secuenciador_init_pkg.sv
// rtl/secuenciador_init_pkg.sv - shared types, bus idle value and default RTC init table
package secuenciador_init_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    GAP,
    DONE
  } estado_e;

  // Wide all-ones constant; callers truncate it to their own bus width.
  localparam logic [63:0] BUS_IDLE = '1;

  localparam int N_DEF = 5;

  // Entry 0 sits in the least significant byte.
  localparam logic [N_DEF*8-1:0] INIT_ADDR = {8'h00, 8'h04, 8'h14, 8'hD2, 8'h02};
  localparam logic [N_DEF*8-1:0] INIT_DATA = {8'h01, 8'h02, 8'h02, 8'h10, 8'h00};

  function automatic logic [7:0] def_addr(input int idx);
    if (idx >= 0 && idx < N_DEF) return INIT_ADDR[idx*8 +: 8];
    return 8'hFF;
  endfunction

  function automatic logic [7:0] def_data(input int idx);
    if (idx >= 0 && idx < N_DEF) return INIT_DATA[idx*8 +: 8];
    return 8'hFF;
  endfunction

endpackage

// File: rtl/secuenciador_init_rtc_tabla.sv
// rtl/secuenciador_init_rtc_tabla.sv - (address, data) table lookup; INIT_LOAD_EN makes it writable
module tabla_init_rtc
  import secuenciador_init_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_REGS = 5,
  parameter int CNT_W  = 3
) (
`ifdef INIT_LOAD_EN
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              busy_i,
  input  logic              we_i,
  input  logic [CNT_W-1:0]  widx_i,
  input  logic [DATA_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
`endif
  input  logic [CNT_W-1:0]  idx_i,
  output logic [DATA_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

`ifdef INIT_LOAD_EN
  logic [DATA_W-1:0] addr_q [N_REGS];
  logic [DATA_W-1:0] data_q [N_REGS];

  // Table registers: package defaults on reset, host writes only while the sequencer is idle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_REGS; i++) begin
        addr_q[i] <= (i < N_DEF) ? DATA_W'(def_addr(i)) : DATA_W'(BUS_IDLE);
        data_q[i] <= (i < N_DEF) ? DATA_W'(def_data(i)) : DATA_W'(BUS_IDLE);
      end
    end else if (we_i && !busy_i && int'(widx_i) < N_REGS) begin
      addr_q[widx_i] <= waddr_i;
      data_q[widx_i] <= wdata_i;
    end
  end

  // Read port; unreachable indices return the idle pattern.
  always_comb begin
    addr_o = DATA_W'(BUS_IDLE);
    data_o = DATA_W'(BUS_IDLE);
    if (int'(idx_i) < N_REGS) begin
      addr_o = addr_q[idx_i];
      data_o = data_q[idx_i];
    end
  end
`else
  // Constant ROM lookup; unreachable indices return the idle pattern.
  always_comb begin
    addr_o = DATA_W'(BUS_IDLE);
    data_o = DATA_W'(BUS_IDLE);
    if (int'(idx_i) < N_REGS && int'(idx_i) < N_DEF) begin
      addr_o = DATA_W'(def_addr(int'(idx_i)));
      data_o = DATA_W'(def_data(int'(idx_i)));
    end
  end
`endif

endmodule

// File: rtl/secuenciador_init_rtc.sv
// rtl/secuenciador_init_rtc.sv - RTC init sequencer: two-phase bus writes from a table; option INIT_LOAD_EN
module secuenciador_init_rtc
  import secuenciador_init_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int N_REGS    = 5,
  parameter int CNT_W     = 3,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
`ifdef INIT_LOAD_EN
  input  logic              tbl_we,
  input  logic [CNT_W-1:0]  tbl_idx,
  input  logic [DATA_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
`endif
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  cuenta,
  output logic [DATA_W-1:0] salida,
  output logic              a_d,
  output logic              c_s_n,
  output logic              wr_n
);

  localparam int TMR_MAX = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam logic [DATA_W-1:0] IDLE_BYTE = DATA_W'(BUS_IDLE);

  estado_e           state_q, state_d;
  logic [TMR_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  cuenta_q, cuenta_d;
  logic              phase_q, phase_d;   // 1 = address phase
  logic [DATA_W-1:0] salida_q, salida_d;
  logic              a_d_q, a_d_d;
  logic              c_s_n_q, c_s_n_d;
  logic              wr_n_q, wr_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              phase_end;
  logic [CNT_W-1:0]  idx_nxt;
  logic [DATA_W-1:0] rom_addr, rom_data;

  // Table index for the next SETUP, derived from registers only so the lookup has no feedback path.
  always_comb begin
    idx_nxt = cuenta_q;
    if (state_q == IDLE) idx_nxt = '0;
    else if (!phase_q)   idx_nxt = cuenta_q + 1'b1;
  end

  tabla_init_rtc #(
    .DATA_W (DATA_W),
    .N_REGS (N_REGS),
    .CNT_W  (CNT_W)
  ) u_tabla (
`ifdef INIT_LOAD_EN
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .busy_i  (busy_q),
    .we_i    (tbl_we),
    .widx_i  (tbl_idx),
    .waddr_i (tbl_addr),
    .wdata_i (tbl_data),
`endif
    .idx_i   (idx_nxt),
    .addr_o  (rom_addr),
    .data_o  (rom_data)
  );

  // Next state and next registered outputs; every output changes together with the state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cuenta_d  = cuenta_q;
    phase_d   = phase_q;
    salida_d  = salida_q;
    a_d_d     = a_d_q;
    c_s_n_d   = c_s_n_q;
    wr_n_d    = wr_n_q;
    busy_d    = busy_q;
    done_d    = done_q;
    phase_end = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = SETUP;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          cuenta_d = '0;
          phase_d  = 1'b1;
          c_s_n_d  = 1'b0;
          wr_n_d   = 1'b1;
          a_d_d    = 1'b1;
          salida_d = rom_addr;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = TMR_W'(PULSE_CYC - 1);
        wr_n_d  = 1'b0;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          wr_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (GAP_CYC > 0) begin
          state_d  = GAP;
          cnt_d    = TMR_W'(GAP_CYC - 1);
          c_s_n_d  = 1'b1;
          a_d_d    = 1'b1;
          salida_d = IDLE_BYTE;
        end else begin
          phase_end = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) phase_end = 1'b1;
        else             cnt_d = cnt_q - 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (phase_end) begin
      if (phase_q) begin
        state_d  = SETUP;
        phase_d  = 1'b0;
        c_s_n_d  = 1'b0;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b0;
        salida_d = rom_data;
      end else if (cuenta_q == CNT_W'(N_REGS - 1)) begin
        state_d  = DONE;
        busy_d   = 1'b0;
        c_s_n_d  = 1'b1;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        salida_d = IDLE_BYTE;
      end else begin
        state_d  = SETUP;
        cuenta_d = cuenta_q + 1'b1;
        phase_d  = 1'b1;
        c_s_n_d  = 1'b0;
        wr_n_d   = 1'b1;
        a_d_d    = 1'b1;
        salida_d = rom_addr;
      end
    end

    // Abort wins over everything else once a sequence is under way.
    if (abort && state_q != IDLE) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      c_s_n_d  = 1'b1;
      wr_n_d   = 1'b1;
      a_d_d    = 1'b1;
      salida_d = IDLE_BYTE;
    end
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cuenta_q <= '0;
      phase_q  <= 1'b1;
      salida_q <= IDLE_BYTE;
      a_d_q    <= 1'b1;
      c_s_n_q  <= 1'b1;
      wr_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cuenta_q <= cuenta_d;
      phase_q  <= phase_d;
      salida_q <= salida_d;
      a_d_q    <= a_d_d;
      c_s_n_q  <= c_s_n_d;
      wr_n_q   <= wr_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign cuenta = cuenta_q;
  assign salida = salida_q;
  assign a_d    = a_d_q;
  assign c_s_n  = c_s_n_q;
  assign wr_n   = wr_n_q;

endmodule

// File: tb/tb_secuenciador_init_rtc.sv
// tb/tb_secuenciador_init_rtc.sv - randomized self-checking bench for secuenciador_init_rtc; option INIT_LOAD_EN
module tb_secuenciador_init_rtc;

  localparam int N     = 5;
  localparam int P     = 4;
  localparam int G     = 2;
  localparam int PH    = P + G + 2;
  localparam int TOTAL = 2 * N * PH;
  localparam logic [31:0] CNT_MASK = 32'h0000_0700;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       busy;
  logic       done;
  logic [2:0] cuenta;
  logic [7:0] salida;
  logic       a_d;
  logic       c_s_n;
  logic       wr_n;
`ifdef INIT_LOAD_EN
  logic       tbl_we;
  logic [2:0] tbl_idx;
  logic [7:0] tbl_addr;
  logic [7:0] tbl_data;
  bit         busy_wr;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit done_exp = 1'b0;

  logic [7:0] ref_addr [N] = '{8'h02, 8'hD2, 8'h14, 8'h04, 8'h00};
  logic [7:0] ref_data [N] = '{8'h00, 8'h10, 8'h02, 8'h02, 8'h01};

  always #5 clk = ~clk;

  secuenciador_init_rtc #(
    .DATA_W    (8),
    .N_REGS    (N),
    .CNT_W     (3),
    .PULSE_CYC (P),
    .GAP_CYC   (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
`ifdef INIT_LOAD_EN
    .tbl_we   (tbl_we),
    .tbl_idx  (tbl_idx),
    .tbl_addr (tbl_addr),
    .tbl_data (tbl_data),
`endif
    .busy     (busy),
    .done     (done),
    .cuenta   (cuenta),
    .salida   (salida),
    .a_d      (a_d),
    .c_s_n    (c_s_n),
    .wr_n     (wr_n)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] pk(input logic bz, input logic dn, input logic cs, input logic wr,
                                     input logic ad, input logic [2:0] cu, input logic [7:0] b);
    return {16'd0, bz, dn, cs, wr, ad, cu, b};
  endfunction

  function automatic logic [31:0] obs();
    return pk(busy, done, c_s_n, wr_n, a_d, cuenta, salida);
  endfunction

  // Expected bus picture for cycle c after the start edge, from the phase timing rules.
  function automatic logic [31:0] model(input int c);
    int j, ph, off, e;
    logic ad;
    if (c <= TOTAL) begin
      j   = c - 1;
      ph  = j / PH;
      off = j % PH;
      e   = ph / 2;
      ad  = (ph % 2 == 0);
      if (off <= P + 1)
        return pk(1'b1, 1'b0, 1'b0, !(off >= 1 && off <= P), ad, 3'(e),
                  ad ? ref_addr[e] : ref_data[e]);
      return pk(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'(e), 8'hFF);
    end
    return pk(1'b0, (c == TOTAL + 2), 1'b1, 1'b1, 1'b1, 3'(N - 1), 8'hFF);
  endfunction

  task automatic run_seq(input int abort_at, input int n_spur);
    bit spur [0:127];
    logic [31:0] idle_w;
    for (int i = 0; i < 128; i++) spur[i] = 1'b0;
    if (n_spur > 0) spur[20] = 1'b1;
    for (int i = 1; i < n_spur; i++) spur[$urandom_range(TOTAL, 1)] = 1'b1;
    idle_w = pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= TOTAL + 2; c++) begin
      if (abort_at > 0 && c == abort_at + 1) begin
        abort = 1'b0;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
          chk($sformatf("abort_idle_k%0d", k), obs() & ~CNT_MASK, idle_w);
          @(negedge clk);
        end
        done_exp = 1'b0;
        return;
      end
      chk($sformatf("seq_c%0d", c), obs(), model(c));
      start = spur[c];
      abort = (c == abort_at);
`ifdef INIT_LOAD_EN
      if (busy_wr && c == 10) begin
        tbl_idx  = 3'd1;
        tbl_addr = 8'hAA;
        tbl_data = 8'hBB;
        tbl_we   = 1'b1;
      end else begin
        tbl_we = 1'b0;
      end
`endif
      @(negedge clk);
    end
    start    = 1'b0;
    abort    = 1'b0;
    done_exp = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
`ifdef INIT_LOAD_EN
    tbl_we   = 1'b0;
    tbl_idx  = 3'd0;
    tbl_addr = 8'h00;
    tbl_data = 8'h00;
    busy_wr  = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("reset", obs(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF));
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", obs(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF));

    run_seq(0, 0);
    run_seq(0, 3);
    chk("done_before_restart", {31'd0, done}, {31'd0, done_exp});
    run_seq(0, 2);

    // Abort inside the data phase of entry 2.
    run_seq(5 * PH + 1 + int'($urandom_range(PH - 1, 0)), 0);

    // Abort alone in IDLE, then start together with abort: neither may do anything.
    run_seq(0, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_idle", obs() & ~CNT_MASK, pk(1'b0, done_exp, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF));
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("start_abort_k%0d", k), obs() & ~CNT_MASK,
          pk(1'b0, done_exp, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF));
      @(negedge clk);
    end

    for (int r = 0; r < 4; r++) begin
      if ($urandom_range(1, 0) == 1) run_seq(int'($urandom_range(TOTAL + 1, 1)), int'($urandom_range(3, 0)));
      else                           run_seq(0, int'($urandom_range(3, 0)));
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end

    // Reset in the middle of a strobe.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_strobe", obs(), model(3));
    #2 rst_n = 1'b0;
    #1 chk("async_reset", obs(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF));
    @(negedge clk);
    rst_n = 1'b1;
    done_exp = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("post_reset_k%0d", k), obs(), pk(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 3'd0, 8'hFF));
    end

`ifdef INIT_LOAD_EN
    tbl_idx  = 3'd1;
    tbl_addr = 8'h30;
    tbl_data = 8'h55;
    tbl_we   = 1'b1;
    @(negedge clk);
    ref_addr[1] = 8'h30;
    ref_data[1] = 8'h55;
    tbl_idx  = 3'd5;
    tbl_addr = 8'h77;
    tbl_data = 8'h77;
    @(negedge clk);
    tbl_we  = 1'b0;
    busy_wr = 1'b1;
`endif
    run_seq(0, 0);
`ifdef INIT_LOAD_EN
    busy_wr = 1'b0;
    tbl_we  = 1'b0;
    run_seq(0, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
